// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx
// Description : Serial frame receiver for start / 8 data (LSB first) /
//               parity / stop frames. Recomputes parity on the received
//               byte, flags parity and framing errors and keeps a saturating
//               count of errored frames. Break conditions (line held low
//               after the stop sample) are absorbed in WAIT_IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       sdi,
    input  logic       clr_cnt,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_DATA      = 3'd1;
    localparam logic [2:0] c_PARITY    = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    localparam logic [7:0] c_CNT_MAX   = 8'hFF;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic [7:0] r_data;
    logic       r_data_valid;
    logic       r_parity_err;
    logic       r_frame_err;
    logic [7:0] r_err_cnt;
    logic       r_busy;

    logic       w_frame_done;
    logic       w_parity_err;
    logic       w_frame_err;

    // State register; busy is registered from the next state so it tracks the FSM exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != c_IDLE);
        end
    end

    // Next-state logic; every transition is qualified by the sample strobe
    always_comb begin
        w_next_state = r_state;
        if (bit_en) begin
            case (r_state)
                c_IDLE:      if (!sdi) w_next_state = c_DATA;
                c_DATA:      if (r_bit_cnt == 3'd7) w_next_state = c_PARITY;
                c_PARITY:    w_next_state = c_STOP;
                c_STOP:      w_next_state = sdi ? c_IDLE : c_WAIT_IDLE;
                c_WAIT_IDLE: if (sdi) w_next_state = c_IDLE;
                default:     w_next_state = c_IDLE;
            endcase
        end
    end

    // Frame-completion decode: the stop sample closes the frame regardless of its value
    always_comb begin
        w_frame_done = bit_en && (r_state == c_STOP);
        w_parity_err = r_par ^ (^r_shift);
        w_frame_err  = ~sdi;
    end

    // Bit counter, data shift register and received parity bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
        end else if (bit_en) begin
            case (r_state)
                c_IDLE: begin
                    if (!sdi) r_bit_cnt <= 3'd0;
                end
                c_DATA: begin
                    r_shift[r_bit_cnt] <= sdi;
                    r_bit_cnt          <= r_bit_cnt + 3'd1;
                end
                c_PARITY: r_par <= sdi;
                default: ;
            endcase
        end
    end

    // Frame results: captured on the stop sample and held until the next frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= w_frame_done;
            if (w_frame_done) begin
                r_data       <= r_shift;
                r_parity_err <= w_parity_err;
                r_frame_err  <= w_frame_err;
            end
        end
    end

    // Saturating errored-frame counter; a clear request overrides a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (clr_cnt) begin
            r_err_cnt <= 8'h00;
        end else if (w_frame_done && (w_parity_err || w_frame_err) && (r_err_cnt != c_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign err_cnt    = r_err_cnt;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_rx
// Description : Self-checking bench for parity_frame_rx. Expected frame
//               results are queued when a frame is driven and compared when
//               data_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       sdi = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    logic [7:0] exp_cnt = 8'h00;
    int         checks = 0;
    int         failures = 0;
    logic       prev_dv = 1'b0;

    parity_frame_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .clr_cnt    (clr_cnt),
        .data       (data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every data_valid pulse pops and checks one expected frame
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && data_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dv: data_valid=1 data=%h with no frame pending", data);
            end else begin
                e = q.pop_front();
                if (data !== e.d || parity_err !== e.pe || frame_err !== e.fe || err_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL frame: got data=%h pe=%b fe=%b cnt=%h, want data=%h pe=%b fe=%b cnt=%h",
                             data, parity_err, frame_err, err_cnt, e.d, e.pe, e.fe, e.cnt);
                end
            end
            checks++;
            if (prev_dv) begin
                failures++;
                $display("FAIL dv_pulse: data_valid high two cycles in a row, want single pulse");
            end
        end
        prev_dv = data_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bit_en  = 1'b0;
            sdi     = b;
            clr_cnt = 1'b0;
        end
        @(negedge clk);
        bit_en  = 1'b1;
        sdi     = b;
        clr_cnt = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input int gap, input logic clr_stop);
        exp_t e;
        e.d  = d;
        e.pe = p ^ (^d);
        e.fe = ~stp;
        if (clr_stop)
            exp_cnt = 8'h00;
        else if ((e.pe || e.fe) && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
        e.cnt = exp_cnt;
        q.push_back(e);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(stp, gap);
        clr_cnt = clr_stop;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            bit_en  = 1'b0;
            sdi     = 1'b1;
            clr_cnt = 1'b0;
            n++;
        end
        repeat (2) begin
            @(negedge clk);
            bit_en  = 1'b0;
            sdi     = 1'b1;
            clr_cnt = 1'b0;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d frames never completed, want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bit_en = 1'b1;
            sdi    = i[0];
        end
        checks++;
        if (data !== 8'h00 || data_valid !== 1'b0 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || err_cnt !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals: data=%h dv=%b pe=%b fe=%b cnt=%h busy=%b, want all zero",
                     data, data_valid, parity_err, frame_err, err_cnt, busy);
        end
        @(negedge clk);
        sdi   = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 0);
            if (i > 0) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_busy: busy=%b, want 0", busy);
                end
            end
        end
        wait_drain("reset");
    endtask

    task automatic test_good();
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
        wait_drain("good");
        checks++;
        if (data !== 8'h01 || err_cnt !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL good_hold: data=%h cnt=%h busy=%b, want 01 00 0", data, err_cnt, busy);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h03, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 0, 1'b0);
        wait_drain("parity");
        checks++;
        if (parity_err !== 1'b0 || err_cnt !== 8'h01) begin
            failures++;
            $display("FAIL parity_after: pe=%b cnt=%h, want 0 01", parity_err, err_cnt);
        end
    endtask

    task automatic test_break();
        send_frame(8'h55, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 0);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL break_busy: busy=%b at low strobe %0d, want 1", busy, i);
            end
        end
        send_bit(1'b1, 0);
        @(negedge clk);
        bit_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b1 || q.size() != 0) begin
            failures++;
            $display("FAIL break_exit: busy=%b fe=%b pending=%0d, want 0 1 0", busy, frame_err, q.size());
        end
        wait_drain("break");
    endtask

    task automatic test_gating_and_reset();
        send_frame(8'hC3, 1'b0, 1'b1, 3, 1'b0);
        wait_drain("gating");
        // partial frame: start plus four data bits, then reset
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        @(negedge clk);
        bit_en = 1'b0;
        sdi    = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || data !== 8'h00 || err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL midreset: busy=%b dv=%b data=%h cnt=%h, want 0 0 00 00",
                     busy, data_valid, data, err_cnt);
        end
        rst_n   = 1'b1;
        exp_cnt = 8'h00;
        send_frame(8'h7E, 1'b0, 1'b1, 0, 1'b0);
        wait_drain("post_reset");
    endtask

    task automatic test_counter();
        for (int i = 0; i < 260; i++) send_frame(8'h03, 1'b1, 1'b1, 0, 1'b0);
        wait_drain("saturate");
        checks++;
        if (err_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL saturate: err_cnt=%h, want ff", err_cnt);
        end
        // clear in the data_valid cycle of an error frame
        send_frame(8'h80, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        bit_en  = 1'b0;
        sdi     = 1'b1;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        exp_cnt = 8'h00;
        checks++;
        if (err_cnt !== 8'h00) begin
            failures++;
            $display("FAIL clr_in_dv: err_cnt=%h, want 00", err_cnt);
        end
        // clear coincident with the increment, then one more error frame
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
        send_bit(1'b1, 0);
        wait_drain("clr_wins");
        checks++;
        if (err_cnt !== 8'h01) begin
            failures++;
            $display("FAIL cnt_after_clr: err_cnt=%h, want 01", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_parity();
        test_break();
        test_gating_and_reset();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver that deframes start/8-data/parity/stop frames, recomputes parity on the received byte and flags parity and framing errors. It is the receive end of the link whose transmit side is the team's combinational 8-bit parity generator (parity bit = XOR of all 8 data bits: 1 when the count of ones is odd). It sits between a bit-rate sampler, which supplies one qualified sample per bit time, and byte-wide consumer logic.

## Interface
- No parameters; frame format fixed at 8 data bits + 1 parity bit.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- bit_en  input  1  sample strobe; sdi is consumed only in cycles with bit_en=1.
- sdi  input  1  serial data line; idle level 1.
- clr_cnt  input  1  synchronous clear of err_cnt.
- data  output  8  last received byte; held until next frame completes.
- data_valid  output  1  single-cycle pulse per completed frame.
- parity_err  output  1  1 when received parity bit != ^data; held with data.
- frame_err  output  1  1 when stop bit sampled as 0; held with data.
- err_cnt  output  8  count of frames with any error, saturating at 255.
- busy  output  1  1 whenever FSM is not IDLE.

## Operation
- Bit order on the line: start(0), d0..d7 (LSB first), parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE. All transitions occur only in cycles with bit_en=1; with bit_en=0 the FSM, shift register and bit counter hold.
- IDLE: sdi=0 -> DATA, bit counter cleared to 0. sdi=1 -> stay.
- DATA: shift sdi into bit position [counter]; counter increments 0..7; after the sample at counter=7 -> PARITY.
- PARITY: store received parity bit -> STOP.
- STOP: sdi=1 -> IDLE; sdi=0 -> WAIT_IDLE. In both cases the frame completes: data <= assembled byte, parity_err <= (received parity != XOR of the 8 bits), frame_err <= ~sdi, data_valid pulses.
- WAIT_IDLE: line held low (break); stay until a bit_en sample with sdi=1, then -> IDLE. A 0 sample here never starts a new frame.
- Parity check is even-total: XOR of 8 data bits and parity bit must be 0.
- err_cnt increments by 1 per completed frame with parity_err or frame_err (one increment even if both); saturates at 8'hFF. clr_cnt=1 forces 0; clr_cnt and an increment in the same cycle -> result 0 (clear wins).
- A frame with errors still updates data and still pulses data_valid.

## Timing
- Reset values: data=8'h00, data_valid=0, parity_err=0, frame_err=0, err_cnt=8'h00, busy=0, FSM=IDLE, counter=0.
- rst_n low mid-frame: immediate return to IDLE, partial byte discarded, no data_valid.
- All outputs are registered. data, parity_err, frame_err, err_cnt update and data_valid is high in the cycle after the clk edge that samples the stop bit; data_valid is low the following cycle regardless of bit_en.
- busy rises in the cycle after the start-bit sample, falls in the cycle after the stop-bit sample (or after leaving WAIT_IDLE).
- Minimum frame: 11 bit_en samples; back-to-back frames allowed (start bit may be the sample right after the stop sample).
- bit_en may be high every cycle; no minimum gap between strobes.

## Test plan
- Reset: assert rst_n=0 with sdi toggling -> all outputs at reset values; release, sdi=1 for 5 strobes -> busy=0, no data_valid.
- Good frame: byte 8'hA5 (parity 0), stop 1, bit_en every cycle -> one data_valid pulse, data=8'hA5, parity_err=0, frame_err=0, err_cnt=0; then back-to-back 8'h01 (parity 1) -> data=8'h01, no errors.
- Parity error: byte 8'h03 sent with parity bit 1 -> data=8'h03, parity_err=1, err_cnt=1; next frame 8'hF0 parity 0 -> parity_err returns to 0, err_cnt stays 1.
- Framing/break: byte 8'h55, correct parity, stop 0, sdi held 0 for 20 strobes -> data_valid once, frame_err=1, err_cnt+1, busy held 1 and no new frame until sdi=1 sampled.
- Strobe gating and reset mid-frame: 8'hC3 with bit_en=1 only every 4th cycle -> correct data at 11th strobe; separately pulse rst_n low after 4 data bits -> no data_valid, next complete frame received correctly.
- Counter: 260 error frames -> err_cnt saturates at 8'hFF; clr_cnt asserted in the data_valid cycle of an error frame -> err_cnt=0.
